// File: rtl/io_bus_pkg.sv
// Shared types for the processor-side memory-mapped IO bus.
//   io_state_t      : arbiter transaction state
//   io_addr_t       : 32-bit byte address
//   io_data_t       : 32-bit data word
//   IO_TIMEOUT_DATA : read data returned when a peripheral never answers
package io_bus_pkg;

  typedef logic [31:0] io_addr_t;
  typedef logic [31:0] io_data_t;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_ISSUE,
    IO_READ_WAIT
  } io_state_t;

  localparam io_data_t IO_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req         : request vector, one bit per requester
//   ptr         : highest-priority index; search goes upward with wrap-around
//   grant       : one-hot grant (all zero when nothing requests)
//   grant_idx   : index of the granted requester
//   grant_valid : at least one request was present
module rr_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 3
) (
  input  logic [NUM_REQUESTERS-1:0]         req,
  input  logic [$clog2(NUM_REQUESTERS)-1:0] ptr,
  output logic [NUM_REQUESTERS-1:0]         grant,
  output logic [$clog2(NUM_REQUESTERS)-1:0] grant_idx,
  output logic                              grant_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQUESTERS);

  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      cand = (32'(ptr) + i) % NUM_REQUESTERS;
      if (!grant_valid && req[cand[IDX_W-1:0]]) begin
        grant_valid                 = 1'b1;
        grant[cand[IDX_W-1:0]]      = 1'b1;
        grant_idx                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing the memory-mapped IO bus between requesters
// (core IO port, debug/trace unit, host loader), one transaction at a time,
// with a peripheral wait-state handshake and a timeout.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req_valid/req_write          : per-requester request and direction
//   req_address/req_wdata        : per-requester address and write data
//   req_ack                      : one-cycle completion pulse to the owner
//   resp_rdata/resp_error        : read data / timeout flag, valid with req_ack
//   io_write_en/io_read_en       : peripheral strobes
//   io_address/io_write_data     : registered address / write data
//   io_ready                     : peripheral accepts the current strobe
//   io_read_data                 : read data, valid the cycle after accept
module io_arbiter
  import io_bus_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic     [NUM_REQUESTERS-1:0] req_valid,
  input  logic     [NUM_REQUESTERS-1:0] req_write,
  input  io_addr_t [NUM_REQUESTERS-1:0] req_address,
  input  io_data_t [NUM_REQUESTERS-1:0] req_wdata,
  output logic     [NUM_REQUESTERS-1:0] req_ack,
  output io_data_t                      resp_rdata,
  output logic                          resp_error,
  output logic                          io_write_en,
  output logic                          io_read_en,
  output io_addr_t                      io_address,
  output io_data_t                      io_write_data,
  input  logic                          io_ready,
  input  io_data_t                      io_read_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQUESTERS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQUESTERS - 1);

  io_state_t                  state, state_next;
  logic [IDX_W-1:0]           owner;
  logic [NUM_REQUESTERS-1:0]  owner_oh;
  logic                       cap_write;
  logic [IDX_W-1:0]           rr_ptr;
  logic [CNT_W-1:0]           tmo_cnt;

  logic [NUM_REQUESTERS-1:0]  arb_grant;
  logic [IDX_W-1:0]           arb_idx;
  logic                       arb_valid;

  logic                       accepted;
  logic                       timeout_hit;
  logic                       ack_fire;

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr_arbiter (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  always_comb begin
    accepted    = (state == IO_ISSUE) && io_ready;
    // io_ready in the terminal cycle wins over the timeout
    timeout_hit = (state == IO_ISSUE) && (tmo_cnt == CNT_LAST) && !io_ready;
    ack_fire    = (accepted && cap_write) || timeout_hit || (state == IO_READ_WAIT);

    state_next = state;
    case (state)
      IO_IDLE:      if (arb_valid) state_next = IO_ISSUE;
      IO_ISSUE: begin
        if (accepted)         state_next = cap_write ? IO_IDLE : IO_READ_WAIT;
        else if (timeout_hit) state_next = IO_IDLE;
      end
      IO_READ_WAIT: state_next = IO_IDLE;
      default:      state_next = IO_IDLE;
    endcase

    io_write_en = (state == IO_ISSUE) &&  cap_write && !timeout_hit;
    io_read_en  = (state == IO_ISSUE) && !cap_write && !timeout_hit;
    req_ack     = ack_fire ? owner_oh : '0;
    resp_error  = timeout_hit;
    if (state == IO_READ_WAIT) resp_rdata = io_read_data;
    else if (timeout_hit)      resp_rdata = IO_TIMEOUT_DATA;
    else                       resp_rdata = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IO_IDLE;
      owner         <= '0;
      owner_oh      <= '0;
      cap_write     <= 1'b0;
      rr_ptr        <= '0;
      tmo_cnt       <= '0;
      io_address    <= '0;
      io_write_data <= '0;
    end else begin
      state <= state_next;
      if (state == IO_IDLE && arb_valid) begin
        owner         <= arb_idx;
        owner_oh      <= arb_grant;
        cap_write     <= req_write[arb_idx];
        io_address    <= req_address[arb_idx];
        io_write_data <= req_wdata[arb_idx];
        tmo_cnt       <= '0;
      end else if (state == IO_ISSUE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (ack_fire) rr_ptr <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_io_arbiter;
  import io_bus_pkg::*;

  localparam int unsigned N   = 3;
  localparam int unsigned TMO = 15;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_write, req_ack;
  io_addr_t [N-1:0] req_address;
  io_data_t [N-1:0] req_wdata;
  io_data_t       resp_rdata;
  logic           resp_error;
  logic           io_write_en, io_read_en, io_ready;
  io_addr_t       io_address;
  io_data_t       io_write_data, io_read_data;

  always #5 clk = ~clk;

  io_arbiter #(
    .NUM_REQUESTERS(N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .req_ack      (req_ack),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .io_write_en  (io_write_en),
    .io_read_en   (io_read_en),
    .io_address   (io_address),
    .io_write_data(io_write_data),
    .io_ready     (io_ready),
    .io_read_data (io_read_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending request per requester and round-robin pointer.
  int unsigned rr;
  bit          pend_v [N];
  bit          pend_w [N];
  logic [31:0] pend_a [N];
  logic [31:0] pend_d [N];
  bit          rand_arrivals;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic int unsigned pick_owner();
    for (int unsigned k = 0; k < N; k++)
      if (pend_v[(rr + k) % N]) return (rr + k) % N;
    return N;
  endfunction

  task automatic set_req(input int unsigned i, input bit w, input logic [31:0] a, input logic [31:0] d);
    pend_v[i] = 1'b1; pend_w[i] = w; pend_a[i] = a; pend_d[i] = d;
  endtask

  task automatic new_req(input int unsigned i);
    set_req(i, 1'($urandom % 2), $urandom, $urandom);
  endtask

  task automatic clear_reqs();
    for (int unsigned i = 0; i < N; i++) pend_v[i] = 1'b0;
  endtask

  task automatic drive_reqs();
    for (int unsigned i = 0; i < N; i++) begin
      req_valid[i]   = pend_v[i];
      req_write[i]   = pend_w[i];
      req_address[i] = pend_a[i];
      req_wdata[i]   = pend_d[i];
    end
  endtask

  // New requests from idle requesters while a transaction is in flight.
  task automatic arrivals(input int unsigned own);
    if (rand_arrivals)
      for (int unsigned i = 0; i < N; i++)
        if (i != own && !pend_v[i] && ($urandom % 6 == 0)) new_req(i);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_we"},    io_write_en, 0);
    check_eq({tag, "_re"},    io_read_en,  0);
    check_eq({tag, "_ack"},   req_ack,     0);
    check_eq({tag, "_err"},   resp_error,  0);
    check_eq({tag, "_rdata"}, resp_rdata,  0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_reqs();
    drive_reqs();
    io_ready = 1'b0;
    io_read_data = $urandom;
    #1;
    check_quiet("rst");
    check_eq("rst_addr",  io_address,    0);
    check_eq("rst_wdata", io_write_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rr = 0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      drive_reqs();
      io_ready = 1'($urandom % 2);
      io_read_data = $urandom;
      #1;
      check_quiet("idle");
    end
  endtask

  // One transaction from the arbitration cycle to req_ack. io_ready rises
  // after 'delay' strobe cycles, or never when 'tmo' is set.
  task automatic run_txn(input int unsigned delay, input bit tmo, input logic [31:0] rd);
    int unsigned own;
    bit          w, done;
    logic [31:0] a, d;
    own = pick_owner();
    if (own == N) begin
      new_req(0);
      own = pick_owner();
    end
    w = pend_w[own]; a = pend_a[own]; d = pend_d[own];

    @(negedge clk);
    drive_reqs();
    io_ready = 1'($urandom % 2);
    io_read_data = $urandom;
    #1;
    check_quiet("arb");

    done = 1'b0;
    for (int unsigned c = 0; c <= TMO && !done; c++) begin
      @(negedge clk);
      arrivals(own);
      drive_reqs();
      req_address[own] = $urandom;
      req_wdata[own]   = $urandom;
      req_write[own]   = 1'($urandom % 2);
      io_ready = !tmo && (c >= delay);
      io_read_data = $urandom;
      #1;
      if (tmo && c == TMO) begin
        check_eq("tmo_we",    io_write_en, 0);
        check_eq("tmo_re",    io_read_en,  0);
        check_eq("tmo_ack",   req_ack,     32'(1) << own);
        check_eq("tmo_err",   resp_error,  1);
        check_eq("tmo_rdata", resp_rdata,  IO_TIMEOUT_DATA);
        done = 1'b1;
      end else begin
        check_eq("iss_we",    io_write_en,   w);
        check_eq("iss_re",    io_read_en,    !w);
        check_eq("iss_addr",  io_address,    a);
        check_eq("iss_wdata", io_write_data, d);
        check_eq("iss_err",   resp_error,    0);
        check_eq("iss_rdata", resp_rdata,    0);
        if (io_ready && w) check_eq("wr_ack", req_ack, 32'(1) << own);
        else               check_eq("iss_ack", req_ack, 0);
        if (io_ready) done = 1'b1;
      end
    end

    if (!w && !tmo) begin
      @(negedge clk);
      arrivals(own);
      drive_reqs();
      req_address[own] = $urandom;
      io_ready = 1'($urandom % 2);
      io_read_data = rd;
      #1;
      check_eq("rd_ack",   req_ack,     32'(1) << own);
      check_eq("rd_rdata", resp_rdata,  rd);
      check_eq("rd_err",   resp_error,  0);
      check_eq("rd_we",    io_write_en, 0);
      check_eq("rd_re",    io_read_en,  0);
    end
    rr = (own + 1) % N;
  endtask

  initial begin
    int unsigned own;
    reset_n = 1'b0;
    io_ready = 1'b0;
    io_read_data = '0;
    rand_arrivals = 1'b0;
    rr = 0;
    clear_reqs();
    for (int unsigned i = 0; i < N; i++) begin
      pend_w[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0;
    end
    drive_reqs();
    do_reset();

    // single write, zero wait states
    set_req(0, 1'b1, 32'h4, 32'h1FF);
    run_txn(0, 1'b0, 32'h0);
    clear_reqs();
    idle_cycles(2);

    // read from requester 1
    set_req(1, 1'b0, 32'h10, 32'h0);
    run_txn(0, 1'b0, 32'hCAFEF00D);
    clear_reqs();
    idle_cycles(1);

    // all requesters writing continuously from reset: order 0,1,2,0,1,2
    do_reset();
    for (int unsigned i = 0; i < N; i++) set_req(i, 1'b1, $urandom, $urandom);
    for (int unsigned k = 0; k < 6; k++) begin
      own = pick_owner();
      run_txn(0, 1'b0, 32'h0);
      set_req(own, 1'b1, $urandom, $urandom);
    end
    clear_reqs();
    idle_cycles(1);

    // three wait states on a write
    set_req(2, 1'b1, 32'h0000_0030, 32'h1234_5678);
    run_txn(3, 1'b0, 32'h0);
    clear_reqs();
    idle_cycles(1);

    // io_ready arrives exactly in the terminal timeout cycle
    set_req(0, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A);
    run_txn(TMO, 1'b0, 32'h0);
    clear_reqs();
    idle_cycles(1);

    // read timeout, write timeout, then a normal read
    set_req(1, 1'b0, 32'h0000_0050, 32'h0);
    run_txn(0, 1'b1, 32'h0);
    clear_reqs();
    set_req(2, 1'b1, 32'h0000_0054, 32'h0BAD_BEEF);
    run_txn(0, 1'b1, 32'h0);
    clear_reqs();
    set_req(2, 1'b0, 32'h0000_0058, 32'h0);
    run_txn(1, 1'b0, 32'h1357_9BDF);
    clear_reqs();
    idle_cycles(1);

    // move the pointer off 0, then reset in the middle of a transaction
    set_req(0, 1'b1, 32'h60, 32'h61);
    run_txn(0, 1'b0, 32'h0);
    clear_reqs();
    set_req(1, 1'b1, 32'h70, 32'h71);
    @(negedge clk);
    drive_reqs();
    io_ready = 1'b0;
    #1;
    check_quiet("mid_arb");
    @(negedge clk);
    drive_reqs();
    io_ready = 1'b0;
    #1;
    check_eq("mid_we", io_write_en, 1);
    #2;
    reset_n  = 1'b0;
    io_ready = 1'b1;
    #1;
    check_eq("mid_rst_we",  io_write_en, 0);
    check_eq("mid_rst_re",  io_read_en,  0);
    check_eq("mid_rst_ack", req_ack,     0);
    check_eq("mid_rst_err", resp_error,  0);
    clear_reqs();
    @(negedge clk);
    drive_reqs();
    io_ready = 1'b0;
    reset_n = 1'b1;
    rr = 0;
    for (int unsigned i = 0; i < N; i++) set_req(i, 1'b1, $urandom, $urandom);
    run_txn(0, 1'b0, 32'h0);
    clear_reqs();
    idle_cycles(1);

    // randomized traffic
    rand_arrivals = 1'b1;
    for (int unsigned t = 0; t < 300; t++) begin
      if (pick_owner() == N) begin
        idle_cycles($urandom % 3);
        new_req($urandom % N);
      end
      own = pick_owner();
      if ($urandom % 20 == 0)      run_txn(0, 1'b1, $urandom);
      else if ($urandom % 25 == 0) run_txn(TMO, 1'b0, $urandom);
      else                         run_txn($urandom % 4, 1'b0, $urandom);
      if ($urandom % 3 == 0) pend_v[own] = 1'b0;
      else                   new_req(own);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
